// File: rtl/iob_aoi_pkg.sv
// Shared constants for the iob_aoi_pipe block: mode encodings and default widths.
package iob_aoi_pkg;

    localparam logic IOB_AOI_MODE_AOI = 1'b0;
    localparam logic IOB_AOI_MODE_OAI = 1'b1;

    localparam int IOB_AOI_DATA_W_DEF      = 8;
    localparam int IOB_AOI_PIPE_STAGES_DEF = 2;
    localparam int IOB_AOI_CNT_W_DEF       = 16;

endpackage

// File: rtl/iob_aoi_pipe_stage.sv
// One elastic valid/ready register stage; ready is combinational from downstream.
// Handshake: a transfer happens on a rising edge where valid & ready & cke_i are all 1.
module iob_aoi_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Empty, or the held word leaves this cycle: either way the slot is free.
    assign up_ready_o = ~valid_q | dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (cke_i) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/iob_aoi_pipe.sv
// Pipelined bitwise AOI (optionally OAI via IOB_AOI_PIPE_OAI_EN) with elastic stages
// and a wrapping completed-transfer counter.
module iob_aoi_pipe
    import iob_aoi_pkg::*;
#(
    parameter int DATA_W      = IOB_AOI_DATA_W_DEF,
    parameter int PIPE_STAGES = IOB_AOI_PIPE_STAGES_DEF,
    parameter int CNT_W       = IOB_AOI_CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] y_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  cnt_o
);

    // Index 0 is the pipeline input, index PIPE_STAGES the output.
    logic [PIPE_STAGES:0] vld;
    logic [PIPE_STAGES:0] rdy;
    logic [DATA_W-1:0]    dat [PIPE_STAGES+1];
    logic [DATA_W-1:0]    func;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

`ifdef IOB_AOI_PIPE_OAI_EN
    // Mode is consumed before stage 0, so it stays bound to its own operands.
    always_comb begin
        if (mode_i == IOB_AOI_MODE_OAI) begin
            func = ~((a_i | b_i) & (c_i | d_i));
        end else begin
            func = ~((a_i & b_i) | (c_i & d_i));
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign func        = ~((a_i & b_i) | (c_i & d_i));
`endif

    assign vld[0]           = in_valid_i;
    assign dat[0]           = func;
    assign rdy[PIPE_STAGES] = out_ready_i;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        iob_aoi_pipe_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk_i     (clk_i),
            .cke_i     (cke_i),
            .arst_i    (arst_i),
            .up_valid_i(vld[k]),
            .up_ready_o(rdy[k]),
            .up_data_i (dat[k]),
            .dn_valid_o(vld[k+1]),
            .dn_ready_i(rdy[k+1]),
            .dn_data_o (dat[k+1])
        );
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[PIPE_STAGES];
    assign y_o         = vld[PIPE_STAGES] ? dat[PIPE_STAGES] : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (vld[PIPE_STAGES] && out_ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_iob_aoi_pipe.sv
// Directed bench for iob_aoi_pipe (DATA_W=8, PIPE_STAGES=2, CNT_W=4) with a queue scoreboard.
module tb_iob_aoi_pipe;

  localparam int DW = 8;
  localparam int CW = 4;

`ifdef IOB_AOI_PIPE_OAI_EN
  localparam logic [DW-1:0] OAI_EXP = 8'h53;
`else
  localparam logic [DW-1:0] OAI_EXP = 8'h35;
`endif

  logic          clk = 1'b0;
  logic          cke;
  logic          arst;
  logic [DW-1:0] a, b, c, d;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] y;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] cnt;

  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  iob_aoi_pipe #(
    .DATA_W(DW),
    .PIPE_STAGES(2),
    .CNT_W(CW)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_i     (arst),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .d_i        (d),
    .mode_i     (mode),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .y_o        (y),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .cnt_o      (cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic set_ops(input logic [DW-1:0] ta, tb, tc, td, input logic tm);
    a = ta; b = tb; c = tc; d = td; mode = tm;
  endtask

  task automatic push(input logic [DW-1:0] ta, tb, tc, td, input logic tm,
                      input logic [DW-1:0] texp);
    bit done = 0;
    set_ops(ta, tb, tc, td, tm);
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready && cke) begin
        exp_q.push_back(texp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard: compare every output transfer against the queue head
  always @(negedge clk) begin
    if (!arst && cke && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {24'd0, y}, 32'hFFFF_FFFF);
      else check("y_data", {24'd0, y}, {24'd0, exp_q.pop_front()});
    end
  end

  logic [15:0]   tt;
  logic [3:0]    v;
  logic [CW-1:0] base;
  int            accepted;
  logic [DW-1:0] bp_val [5];
  logic [DW-1:0] bp_exp [5];

  initial begin
    tt = 16'h0777;
    bp_val[0] = 8'h01; bp_val[1] = 8'h02; bp_val[2] = 8'h04; bp_val[3] = 8'h08; bp_val[4] = 8'h10;
    bp_exp[0] = 8'hFE; bp_exp[1] = 8'hFD; bp_exp[2] = 8'hFB; bp_exp[3] = 8'hF7; bp_exp[4] = 8'hEF;
    arst = 1'b1; cke = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_ops('0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_cnt", cnt, 0);
    @(negedge clk) arst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // exhaustive truth table, lanes replicated
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      push({DW{v[3]}}, {DW{v[2]}}, {DW{v[1]}}, {DW{v[0]}}, 1'b0, {DW{tt[i]}});
    end
    drain();
    check("cnt_after_16_wrap", cnt, 0);

    // wide vector, 17th transfer wraps counter to 1
    push(8'hF0, 8'hCC, 8'h0F, 8'hAA, 1'b0, 8'h35);
    drain();
    check("cnt_after_17", cnt, 1);
    push(8'hF0, 8'hCC, 8'h0F, 8'hAA, 1'b1, OAI_EXP);
    drain();
    check("cnt_after_oai", cnt, 2);

    // back-pressure: only two slots
    base = cnt;
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      set_ops(8'hFF, bp_val[i], 8'h00, 8'h00, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(bp_exp[i]);
        accepted++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_y_head", y, 8'hFE);

    // clock enable low: nothing moves even with consumer ready
    cke = 1'b0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("cke_cnt_hold", cnt, base);
    check("cke_out_valid_hold", out_valid, 1);
    check("cke_in_ready", in_ready, 1);
    check("cke_y_hold", y, 8'hFE);
    cke = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("bp_cnt_plus2", cnt, base + 4'd2);
    check("bp_empty", out_valid, 0);
    check("bp_y_zero", y, 0);
    for (int i = 2; i < 5; i++) push(8'hFF, bp_val[i], 8'h00, 8'h00, 1'b0, bp_exp[i]);
    drain();
    check("bp_cnt_plus5", cnt, base + 4'd5);

    // full pipeline with ready: simultaneous in/out keeps occupancy
    out_ready = 1'b0;
    push(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
    push(8'h0F, 8'h0F, 8'h00, 8'h00, 1'b0, 8'hF0);
    out_ready = 1'b1;
    push(8'h3C, 8'h3C, 8'h00, 8'h00, 1'b0, 8'hC3);
    check("full_pass_out_valid", out_valid, 1);
    check("full_pass_y", y, 8'hF0);
    drain();

    // reset mid-stream with two results in flight
    out_ready = 1'b0;
    push(8'hAA, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h55);
    push(8'h55, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hAA);
    #2 arst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk) arst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push(8'hF0, 8'hCC, 8'h0F, 8'hAA, 1'b0, 8'h35);
    check("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("lat_y", y, 8'h35);
    drain();
    check("post_rst_cnt", cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
